hazard_unit: RTL
================

# hazard_unit

Pipeline hazard controller for the five-stage core; it is the consumer end of the decode/execute register interface. It samples the execute-stage control and register fields, keeps its own shadow copy of the memory- and writeback-stage destinations, and drives the stall, flush and forwarding controls back into the fetch, decode and execute stages. It also owns the data-memory wait handshake and its timeout.

## Interface
- `REG_ADDR_W`, default 5: register-address width.
- `MEM_TIMEOUT`, default 16: consecutive memory-wait cycles before a forced release. Must be ≥ 2.
- `clk` in 1: single core clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `rs1_d`, `rs2_d` in REG_ADDR_W: source registers in decode.
- `rs1_e`, `rs2_e`, `rd_e` in REG_ADDR_W: source and destination registers in execute.
- `reg_write_e`, `mem_read_e`, `mem_write_e` in 1: execute-stage control.
- `pc_src_e` in 1: branch or jump taken, resolved in execute.
- `dmem_ready` in 1: data memory completes the current access this cycle.
- `stall_f`, `stall_d`, `stall_e`, `stall_m` out 1: hold the PC and the F/D, D/E and E/M registers.
- `flush_d`, `flush_e` out 1: zero the F/D and D/E registers at the next edge.
- `forward_a_e`, `forward_b_e` out 2: ALU operand source select.
- `mem_timeout` out 1: one-cycle pulse when a wait is force-released.

## Operation
- **Shadow state**
  - `rd_m`, `reg_write_m` and `mem_acc_m` (= `mem_read_e | mem_write_e`) capture the execute-stage values each edge.
  - `rd_w` and `reg_write_w` capture `rd_m` and `reg_write_m`.
  - All shadow registers hold while `mem_stall` is asserted.
- **Forwarding**, per operand with source `rsX_e`:
  - `2'b10` (from M) if `reg_write_m`, `rd_m != 0` and `rd_m == rsX_e`.
  - Otherwise `2'b01` (from W) if `reg_write_w`, `rd_w != 0` and `rd_w == rsX_e`.
  - Otherwise `2'b00` (register file). M takes priority over W.
- **Load-use**
  - `lu_stall` = `mem_read_e`, `rd_e != 0` and (`rd_e == rs1_d` or `rd_e == rs2_d`).
  - When set: `stall_f`, `stall_d` and `flush_e` are 1.
- **Control hazard:** when `pc_src_e` is set, `flush_d` and `flush_e` are 1.
- **Memory wait** (`mem_stall` = `mem_acc_m & ~dmem_ready & ~force_rel`)
  - `stall_f`, `stall_d`, `stall_e` and `stall_m` are all 1.
- **Wait FSM**, states IDLE and WAIT:
  - IDLE→WAIT when `mem_stall` is set; the counter loads 1.
  - WAIT→IDLE when `dmem_ready` is set; the counter clears.
  - In WAIT the counter increments each stalled cycle.
  - `force_rel` is asserted combinationally when the counter equals `MEM_TIMEOUT - 1` in WAIT with `dmem_ready` low.
  - On `force_rel`: `mem_timeout` is 1 that cycle, all stalls drop, the pipeline advances, and the FSM goes to IDLE with the counter cleared.
- **Priority**
  - `mem_stall` overrides everything: flushes are 0 while it is set, and `pc_src_e` and `lu_stall` are re-evaluated once it releases.
  - `pc_src_e` overrides `lu_stall`: `flush_d = flush_e = 1` and `stall_f = stall_d = 0`.
- **Reset:** all shadow registers 0, FSM IDLE, counter 0. While `rst_n` is low every output is forced to 0.

## Timing
- Stall, flush and forward outputs are combinational from inputs and state in the same cycle. `mem_timeout` is combinational from FSM state.
- A load-use stall lasts exactly one cycle. The following cycle has the load in M with a bubble in E, so `lu_stall` clears by construction.
- A wait of N cycles (N < MEM_TIMEOUT) gives exactly N cycles of `stall_*`.
- Reset assertion mid-wait aborts it immediately and asynchronously. Release is synchronous to the next `clk` edge.

## Configuration
- `HAZARD_FWD_EN` defined:
  - Forwarding operates as described above.
- `HAZARD_FWD_EN` undefined:
  - `forward_*_e` are tied to `2'b00`.
  - RAW hazards resolve by stalling. `stall_f` and `stall_d` are set and `flush_e` is 1 when `rs1_d` or `rs2_d` (non-zero) matches `rd_e` with `reg_write_e`, or `rd_m` with `reg_write_m`.
  - A W-stage match never stalls, because the register file is write-first.

## Structure
- `hazard_pkg` holds:
  - `fwd_sel_t` enum: `FWD_RF = 2'b00`, `FWD_W = 2'b01`, `FWD_M = 2'b10`.
  - `mem_wait_state_t` enum: IDLE, WAIT.
- Sub-module `hazard_mem_wait` contains the FSM, the counter, `mem_stall`, `force_rel` and `mem_timeout`.
- The top level contains the shadow registers, forwarding, load-use and priority logic.

## Test plan
- **Forward from M:** `rd_e = 5` with `reg_write_e`, next cycle `rs1_e = 5` → `forward_a_e = 10`.
- **M over W, and x0:** `rd_m = rd_w = 7` (both writing) with `rs2_e = 7` → `forward_b_e = 10`. With `rd = 0` → `00`.
- **Load-use:** lw `rd_e = 3` with `rs2_d = 3` → `stall_f = stall_d = flush_e = 1` for exactly one cycle, then two cycles later `forward_b_e = 01`.
- **Branch:** `pc_src_e = 1` alone → `flush_d = flush_e = 1`. `pc_src_e = 1` together with a load-use match → same result, with `stall_f = stall_d = 0`.
- **Memory wait:** `mem_acc_m` with `dmem_ready` low 3 cycles → all four stalls 1 for exactly 3 cycles and shadow registers held.
- **Timeout:** `MEM_TIMEOUT = 4`, `dmem_ready` never high → stalls for 3 cycles, `mem_timeout` pulse on cycle 4 with stalls 0. `rst_n` low mid-wait → all outputs 0 immediately.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hazard_pkg                                                |
// | Purpose  : Shared types for the pipeline hazard controller:          |
// |            forwarding-select encoding and memory-wait FSM states.    |
// | Options  : HAZARD_FWD_EN (used by hazard_unit)                       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package hazard_pkg;

  // ALU operand source select driven back into execute
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  // Data-memory wait handshake states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_wait_state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_mem_wait.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hazard_mem_wait                                           |
// | Purpose  : Data-memory wait handshake. Raises mem_stall while an     |
// |            access sits in M without dmem_ready, and force-releases   |
// |            the pipeline after MEM_TIMEOUT-1 stalled cycles.          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module hazard_mem_wait
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_acc_m,
  input  logic dmem_ready,
  output logic mem_stall,
  output logic force_rel,
  output logic mem_timeout
);

  localparam int                c_cnt_w    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MEM_TIMEOUT - 1);

  mem_wait_state_t      r_state;
  mem_wait_state_t      w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;

  // The counter holds the number of cycles already stalled, so the release
  // fires on the cycle after MEM_TIMEOUT-1 stalls without ready.
  assign force_rel   = (r_state == WAIT) && (r_cnt == c_cnt_last) && !dmem_ready;
  assign mem_stall   = mem_acc_m && !dmem_ready && !force_rel;
  assign mem_timeout = force_rel;

  // State and counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and counter update
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (mem_stall) begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = c_cnt_w'(1);
        end
      end
      WAIT: begin
        if (dmem_ready || force_rel) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + c_cnt_w'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hazard_unit                                               |
// | Purpose  : Five-stage pipeline hazard controller: shadow M/W         |
// |            destinations, operand forwarding, load-use and RAW        |
// |            stalls, branch flushes and memory-wait stalls.            |
// | Options  : HAZARD_FWD_EN - enables M/W forwarding; when undefined    |
// |            forwarding is tied off and RAW hazards stall instead.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rs1_e,
  input  logic [REG_ADDR_W-1:0] rs2_e,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic                  reg_write_e,
  input  logic                  mem_read_e,
  input  logic                  mem_write_e,
  input  logic                  pc_src_e,
  input  logic                  dmem_ready,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  stall_m,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic [1:0]            forward_a_e,
  output logic [1:0]            forward_b_e,
  output logic                  mem_timeout
);

  logic [REG_ADDR_W-1:0] r_rd_m;
  logic                  r_reg_write_m;
  logic                  r_mem_acc_m;
  logic [REG_ADDR_W-1:0] r_rd_w;
  logic                  r_reg_write_w;

  logic     w_mem_stall;
  logic     w_force_rel;
  logic     w_mem_timeout;
  logic     w_lu_stall;
  logic     w_data_stall;
  fwd_sel_t w_fwd_a;
  fwd_sel_t w_fwd_b;
  logic     w_stall_f;
  logic     w_stall_d;
  logic     w_stall_e;
  logic     w_stall_m;
  logic     w_flush_d;
  logic     w_flush_e;

  hazard_mem_wait #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_acc_m   (r_mem_acc_m),
    .dmem_ready  (dmem_ready),
    .mem_stall   (w_mem_stall),
    .force_rel   (w_force_rel),
    .mem_timeout (w_mem_timeout)
  );

  // Shadow copy of the M and W destinations; frozen while memory stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_m        <= '0;
      r_reg_write_m <= 1'b0;
      r_mem_acc_m   <= 1'b0;
      r_rd_w        <= '0;
      r_reg_write_w <= 1'b0;
    end else if (!w_mem_stall) begin
      r_rd_m        <= rd_e;
      r_reg_write_m <= reg_write_e;
      r_mem_acc_m   <= mem_read_e | mem_write_e;
      r_rd_w        <= r_rd_m;
      r_reg_write_w <= r_reg_write_m;
    end
  end

  // A load in E whose destination feeds the instruction in decode
  assign w_lu_stall = mem_read_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

`ifdef HAZARD_FWD_EN
  function automatic fwd_sel_t fwd_pick(
    input logic [REG_ADDR_W-1:0] a_rs,
    input logic [REG_ADDR_W-1:0] a_rd_m,
    input logic                  a_wr_m,
    input logic [REG_ADDR_W-1:0] a_rd_w,
    input logic                  a_wr_w
  );
    if (a_wr_m && (a_rd_m != '0) && (a_rd_m == a_rs)) begin
      return FWD_M;
    end else if (a_wr_w && (a_rd_w != '0) && (a_rd_w == a_rs)) begin
      return FWD_W;
    end
    return FWD_RF;
  endfunction

  // Operand forwarding, M has priority over W
  always_comb begin
    w_fwd_a = fwd_pick(rs1_e, r_rd_m, r_reg_write_m, r_rd_w, r_reg_write_w);
    w_fwd_b = fwd_pick(rs2_e, r_rd_m, r_reg_write_m, r_rd_w, r_reg_write_w);
  end

  assign w_data_stall = w_lu_stall;

  logic w_unused;
  assign w_unused = w_force_rel;
`else
  function automatic logic raw_hit(
    input logic [REG_ADDR_W-1:0] a_rs,
    input logic [REG_ADDR_W-1:0] a_rd_e,
    input logic                  a_wr_e,
    input logic [REG_ADDR_W-1:0] a_rd_m,
    input logic                  a_wr_m
  );
    // W is not checked: the register file writes before it is read
    return (a_rs != '0) && ((a_wr_e && (a_rd_e == a_rs)) || (a_wr_m && (a_rd_m == a_rs)));
  endfunction

  assign w_fwd_a = FWD_RF;
  assign w_fwd_b = FWD_RF;

  assign w_data_stall = w_lu_stall
                      || raw_hit(rs1_d, rd_e, reg_write_e, r_rd_m, r_reg_write_m)
                      || raw_hit(rs2_d, rd_e, reg_write_e, r_rd_m, r_reg_write_m);

  logic w_unused;
  assign w_unused = ^{w_force_rel, rs1_e, rs2_e, r_rd_w, r_reg_write_w};
`endif

  // Stall/flush priority: memory wait, then taken branch, then data hazard
  always_comb begin
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_stall_m = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    if (w_mem_stall) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_stall_e = 1'b1;
      w_stall_m = 1'b1;
    end else if (pc_src_e) begin
      w_flush_d = 1'b1;
      w_flush_e = 1'b1;
    end else if (w_data_stall) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_flush_e = 1'b1;
    end
  end

  // Every output reads as zero while reset is held
  assign stall_f     = rst_n & w_stall_f;
  assign stall_d     = rst_n & w_stall_d;
  assign stall_e     = rst_n & w_stall_e;
  assign stall_m     = rst_n & w_stall_m;
  assign flush_d     = rst_n & w_flush_d;
  assign flush_e     = rst_n & w_flush_e;
  assign forward_a_e = rst_n ? w_fwd_a : FWD_RF;
  assign forward_b_e = rst_n ? w_fwd_b : FWD_RF;
  assign mem_timeout = rst_n & w_mem_timeout;

endmodule
`default_nettype wire
